// File: rtl/mips_mem_arbiter.sv
// Single-port arbiter for the unified IM/DM memory of mips_32, with a loader/debug port.
// One access per cycle; read data returns one cycle after the grant.
module mips_mem_arbiter #(
  parameter int AW       = 10,
  parameter int DEPTH    = 1024,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          im_req,
  input  logic [AW-1:0] im_addr,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_wdata,
  input  logic          ld_lock,
  output logic          im_gnt,
  output logic          dm_gnt,
  output logic          ld_gnt,
  output logic          im_rvalid,
  output logic          dm_rvalid,
  output logic          ld_rvalid,
  output logic [31:0]   rdata,
  output logic          err,
  output logic          cpu_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

  localparam int          CW    = $clog2(MAX_WAIT + 1);
  localparam logic [AW:0] LIMIT = (AW + 1)'(DEPTH);

  state_t          state, state_next;
  logic [CW-1:0]   wait_cnt;
  logic            im_force;
  logic            rd_pending, rd_oor;
  logic [2:0]      rd_owner;
  logic            any_gnt, acc_we, oor, rd_live;
  logic [AW-1:0]   acc_addr;
  logic [31:0]     acc_wdata;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk1) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (ld_req && ld_lock) state_next = LOAD;
      LOAD:    if (!ld_lock)          state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign im_force = (wait_cnt == CW'(MAX_WAIT));

  always_comb begin
    im_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    ld_gnt    = 1'b0;
    cpu_stall = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (ld_req)                  ld_gnt = 1'b1;
          else if (im_req && im_force) im_gnt = 1'b1;
          else if (dm_req)             dm_gnt = 1'b1;
          else if (im_req)             im_gnt = 1'b1;
          cpu_stall = (im_req && !im_gnt) || (dm_req && !dm_gnt);
        end
        LOAD: begin
          // The exit cycle (ld_lock low) grants nothing but still holds the core.
          ld_gnt    = ld_req && ld_lock;
          cpu_stall = 1'b1;
        end
        default: ;
      endcase
    end

    acc_we    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    if (ld_gnt) begin
      acc_we    = ld_we;
      acc_addr  = ld_addr;
      acc_wdata = ld_wdata;
    end else if (dm_gnt) begin
      acc_we    = dm_we;
      acc_addr  = dm_addr;
      acc_wdata = dm_wdata;
    end else if (im_gnt) begin
      acc_addr  = im_addr;
    end

    any_gnt   = im_gnt || dm_gnt || ld_gnt;
    oor       = any_gnt && ({1'b0, acc_addr} >= LIMIT);
    mem_en    = any_gnt && !oor;
    mem_we    = mem_en && acc_we;
    mem_addr  = mem_en ? acc_addr : '0;
    mem_wdata = mem_we ? acc_wdata : '0;

    // Responses are masked during reset so a read in flight never surfaces.
    rd_live   = !rst && rd_pending;
    im_rvalid = rd_live && rd_owner[0];
    dm_rvalid = rd_live && rd_owner[1];
    ld_rvalid = rd_live && rd_owner[2];
    rdata     = (rd_live && !rd_oor) ? mem_rdata : '0;
    err       = (oor && acc_we) || (rd_live && rd_oor);
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      rd_pending <= 1'b0;
      rd_oor     <= 1'b0;
      rd_owner   <= '0;
      wait_cnt   <= '0;
    end else begin
      rd_pending <= any_gnt && !acc_we;
      rd_oor     <= oor;
      rd_owner   <= {ld_gnt, dm_gnt, im_gnt};
      if (im_req && !im_gnt) begin
        if (!im_force) wait_cnt <= wait_cnt + CW'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed scenarios plus a randomized run,
// all compared cycle by cycle against a transaction-level reference model.
module tb_mips_mem_arbiter;
  localparam int AW       = 10;
  localparam int DEPTH    = 512;
  localparam int MAX_WAIT = 4;

  logic clk1 = 1'b0;
  logic rst, im_req, dm_req, dm_we, ld_req, ld_we, ld_lock;
  logic [AW-1:0] im_addr, dm_addr, ld_addr, mem_addr;
  logic [31:0] dm_wdata, ld_wdata, rdata, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic im_gnt, dm_gnt, ld_gnt, im_rvalid, dm_rvalid, ld_rvalid, err, cpu_stall, mem_en, mem_we;

  int total = 0;
  int bad   = 0;

  logic [31:0] ram       [0:1023] = '{default: 32'h0};
  logic [31:0] model_mem [0:1023] = '{default: 32'h0};

  // Reference model state: loader ownership, IM refusal count, response due next cycle.
  bit          m_load = 1'b0;
  int          m_wait = 0;
  int          m_rv   = -1;
  bit          m_rv_err;
  logic [31:0] m_rv_data;

  // Observed / expected snapshot, ctl = {ld,dm,im gnt, ld,dm,im rvalid, err, stall, mem_en, mem_we}
  logic [9:0]    o_ctl, e_ctl;
  logic [31:0]   o_rdata, e_rdata, o_wdata, e_wdata;
  logic [AW-1:0] o_addr, e_addr;

  mips_mem_arbiter #(.AW(AW), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk1(clk1), .rst(rst),
    .im_req(im_req), .im_addr(im_addr),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_lock(ld_lock),
    .im_gnt(im_gnt), .dm_gnt(dm_gnt), .ld_gnt(ld_gnt),
    .im_rvalid(im_rvalid), .dm_rvalid(dm_rvalid), .ld_rvalid(ld_rvalid),
    .rdata(rdata), .err(err), .cpu_stall(cpu_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk1 = ~clk1;

  // Behavioural single-port RAM answering one cycle after a read strobe.
  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic drive(input bit r, input bit ir, input logic [AW-1:0] ia,
                       input bit dr, input bit dw, input logic [AW-1:0] da, input logic [31:0] dd,
                       input bit lr, input bit lw, input logic [AW-1:0] la, input logic [31:0] ldd,
                       input bit lk);
    rst = r; im_req = ir; im_addr = ia;
    dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
    ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = ldd; ld_lock = lk;
  endtask

  // Samples the DUT mid-cycle, computes what the rules demand, then advances one clock.
  task automatic eval();
    int w;
    logic [AW-1:0] a;
    bit we_, oor, st;
    logic [31:0] wd;
    @(negedge clk1);
    o_ctl   = {ld_gnt, dm_gnt, im_gnt, ld_rvalid, dm_rvalid, im_rvalid, err, cpu_stall, mem_en, mem_we};
    o_rdata = rdata;
    o_addr  = mem_en ? mem_addr : '0;
    o_wdata = mem_we ? mem_wdata : '0;
    e_ctl = '0; e_rdata = '0; e_addr = '0; e_wdata = '0;
    if (rst) begin
      m_load = 1'b0; m_wait = 0; m_rv = -1;
    end else begin
      w = -1;
      if (m_load) begin
        if (ld_req && ld_lock) w = 2;
        st = 1'b1;
      end else begin
        if (ld_req)                          w = 2;
        else if (im_req && m_wait == MAX_WAIT) w = 0;
        else if (dm_req)                     w = 1;
        else if (im_req)                     w = 0;
        st = (im_req && w != 0) || (dm_req && w != 1);
      end
      a = '0; we_ = 1'b0; wd = '0;
      if (w == 0) a = im_addr;
      if (w == 1) begin a = dm_addr; we_ = dm_we; wd = dm_wdata; end
      if (w == 2) begin a = ld_addr; we_ = ld_we; wd = ld_wdata; end
      oor = (w >= 0) && (int'(a) >= DEPTH);
      if (w >= 0) e_ctl[7 + w] = 1'b1;
      if (m_rv >= 0) begin
        e_ctl[4 + m_rv] = 1'b1;
        e_rdata = m_rv_err ? 32'h0 : m_rv_data;
      end
      e_ctl[3] = (w >= 0 && we_ && oor) || (m_rv >= 0 && m_rv_err);
      e_ctl[2] = st;
      e_ctl[1] = (w >= 0) && !oor;
      e_ctl[0] = e_ctl[1] && we_;
      if (e_ctl[1]) e_addr = a;
      if (e_ctl[0]) e_wdata = wd;
      m_rv = -1;
      if (w >= 0 && !we_) begin
        m_rv = w; m_rv_err = oor; m_rv_data = oor ? 32'h0 : model_mem[a];
      end
      if (w >= 0 && we_ && !oor) model_mem[a] = wd;
      m_wait = (im_req && w != 0) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
      if (!m_load && ld_req && ld_lock) m_load = 1'b1;
      else if (m_load && !ld_lock)      m_load = 1'b0;
    end
    @(posedge clk1); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 10'd1, 1, 0, 10'd2, 0, 1, 1, 10'd3, 32'h1, 1);
      eval();
      total++;
      if (o_ctl !== 10'b0 || o_rdata !== 32'h0 || o_addr !== '0 || o_wdata !== 32'h0) begin
        bad++;
        $display("FAIL reset_outputs cyc%0d ctl=%b rdata=%h required all zero", i, o_ctl, o_rdata);
      end
    end
  endtask

  task automatic test_mid_read_reset();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       drive(0, 0, 0, 1, 0, 10'd200, 0, 0, 0, 0, 0, 0);
        1, 2:    drive(1, 0, 0, 1, 0, 10'd200, 0, 0, 0, 0, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      eval();
      total++;
      if (o_ctl !== e_ctl || o_rdata !== e_rdata || o_addr !== e_addr || o_wdata !== e_wdata) begin
        bad++;
        $display("FAIL mid_read_reset cyc%0d ctl=%b exp=%b rdata=%h exp=%h addr=%h exp=%h",
                 i, o_ctl, e_ctl, o_rdata, e_rdata, o_addr, e_addr);
      end
      if (i > 0) begin
        total++;
        if (o_ctl[5] !== 1'b0) begin
          bad++;
          $display("FAIL mid_read_reset_rvalid cyc%0d dm_rvalid=%b required 0", i, o_ctl[5]);
        end
      end
    end
  endtask

  task automatic test_load_burst();
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: drive(0, 1, 0, 0, 0, 0, 0, 1, 1, 10'd0,   32'h280A00C8, 1);
        1: drive(0, 1, 0, 0, 0, 0, 0, 1, 1, 10'd1,   32'h28020001, 1);
        2: drive(0, 1, 0, 0, 0, 0, 0, 1, 1, 10'd200, 32'h00000005, 1);
        3: drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        4: drive(0, 1, 10'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        5: drive(0, 0, 0, 1, 0, 10'd1,   0, 0, 0, 0, 0, 0);
        6: drive(0, 0, 0, 1, 0, 10'd200, 0, 0, 0, 0, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      eval();
      total++;
      if (o_ctl !== e_ctl || o_rdata !== e_rdata || o_addr !== e_addr || o_wdata !== e_wdata) begin
        bad++;
        $display("FAIL load_burst cyc%0d ctl=%b exp=%b rdata=%h exp=%h addr=%h exp=%h wdata=%h exp=%h",
                 i, o_ctl, e_ctl, o_rdata, e_rdata, o_addr, e_addr, o_wdata, e_wdata);
      end
      if (i < 4) begin
        total++;
        if (o_ctl[2] !== 1'b1) begin
          bad++;
          $display("FAIL load_burst_stall cyc%0d cpu_stall=%b required 1", i, o_ctl[2]);
        end
      end
      if (i >= 5) begin
        total++;
        if (o_rdata !== (i == 5 ? 32'h280A00C8 : i == 6 ? 32'h28020001 : 32'h00000005)) begin
          bad++;
          $display("FAIL load_burst_readback cyc%0d rdata=%h", i, o_rdata);
        end
      end
    end
  endtask

  task automatic test_im_starvation();
    logic [2:0] want;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    eval();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 10'd3, 1, 0, 10'd200, 0, 0, 0, 0, 0, 0);
      eval();
      want = (i == 4) ? 3'b001 : 3'b010;
      total++;
      if (o_ctl[9:7] !== want || o_ctl !== e_ctl || o_rdata !== e_rdata || o_addr !== e_addr) begin
        bad++;
        $display("FAIL im_starvation cyc%0d gnt=%b required %b ctl=%b exp=%b rdata=%h exp=%h",
                 i, o_ctl[9:7], want, o_ctl, e_ctl, o_rdata, e_rdata);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(0, 1, 10'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        1: drive(0, 0, 0, 1, 1, 10'd198, 32'd120, 0, 0, 0, 0, 0);
        2: drive(0, 0, 0, 1, 0, 10'd198, 0, 0, 0, 0, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      eval();
      total++;
      if (o_ctl !== e_ctl || o_rdata !== e_rdata || o_addr !== e_addr || o_wdata !== e_wdata) begin
        bad++;
        $display("FAIL back_to_back cyc%0d ctl=%b exp=%b rdata=%h exp=%h addr=%h exp=%h wdata=%h exp=%h",
                 i, o_ctl, e_ctl, o_rdata, e_rdata, o_addr, e_addr, o_wdata, e_wdata);
      end
    end
    total++;
    if (o_ctl[5] !== 1'b1 || o_rdata !== 32'd120) begin
      bad++;
      $display("FAIL back_to_back_data dm_rvalid=%b rdata=%0d required 1 and 120", o_ctl[5], o_rdata);
    end
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(0, 0, 0, 1, 0, 10'(DEPTH), 0, 0, 0, 0, 0, 0);
        1: drive(0, 0, 0, 1, 1, 10'd600, 32'hABCD1234, 0, 0, 0, 0, 0);
        2: drive(0, 0, 0, 1, 0, 10'd88, 0, 0, 0, 0, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      eval();
      total++;
      if (o_ctl !== e_ctl || o_rdata !== e_rdata || o_addr !== e_addr || o_wdata !== e_wdata) begin
        bad++;
        $display("FAIL out_of_range cyc%0d ctl=%b exp=%b rdata=%h exp=%h", i, o_ctl, e_ctl, o_rdata, e_rdata);
      end
      if (i == 0 || i == 1) begin
        total++;
        if (o_ctl[8] !== 1'b1 || o_ctl[1] !== 1'b0 || o_ctl[3] !== (i == 1)) begin
          bad++;
          $display("FAIL out_of_range_grant cyc%0d dm_gnt=%b mem_en=%b err=%b", i, o_ctl[8], o_ctl[1], o_ctl[3]);
        end
      end
      if (i == 1) begin
        total++;
        if (o_ctl[5] !== 1'b1 || o_rdata !== 32'h0 || o_ctl[3] !== 1'b1) begin
          bad++;
          $display("FAIL out_of_range_resp dm_rvalid=%b rdata=%h err=%b required 1/0/1", o_ctl[5], o_rdata, o_ctl[3]);
        end
      end
    end
  endtask

  task automatic test_all_requests();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive(0, 1, 10'd7, 1, 0, 10'd9, 0, 1, 0, 10'd11, 0, 0);
        1: drive(0, 0, 0, 1, 0, 10'd9, 0, 0, 0, 0, 0, 1);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      eval();
      total++;
      if (o_ctl !== e_ctl || o_rdata !== e_rdata || o_addr !== e_addr || o_wdata !== e_wdata) begin
        bad++;
        $display("FAIL all_requests cyc%0d ctl=%b exp=%b rdata=%h exp=%h", i, o_ctl, e_ctl, o_rdata, e_rdata);
      end
    end
  endtask

  task automatic test_random();
    int lock_left = 0;
    bit lr, lk;
    for (int i = 0; i < 600; i++) begin
      if (lock_left == 0 && $urandom_range(0, 19) == 0) lock_left = $urandom_range(1, 6);
      lk = (lock_left > 0);
      lr = lk ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      if (lock_left > 0) lock_left--;
      drive(($urandom_range(0, 49) == 0),
            $urandom_range(0, 1), ($urandom_range(0, 7) == 0) ? 10'($urandom_range(500, 600)) : 10'($urandom_range(0, 63)),
            $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0) ? 10'($urandom_range(500, 600)) : 10'($urandom_range(0, 63)), $urandom,
            lr, $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0) ? 10'($urandom_range(500, 600)) : 10'($urandom_range(0, 63)), $urandom,
            lk);
      eval();
      total++;
      if (o_ctl !== e_ctl || o_rdata !== e_rdata || o_addr !== e_addr || o_wdata !== e_wdata) begin
        bad++;
        $display("FAIL random cyc%0d ctl=%b exp=%b rdata=%h exp=%h addr=%h exp=%h wdata=%h exp=%h",
                 i, o_ctl, e_ctl, o_rdata, e_rdata, o_addr, e_addr, o_wdata, e_wdata);
      end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk1); #1;
    test_reset();
    test_mid_read_reset();
    test_load_burst();
    test_im_starvation();
    test_back_to_back();
    test_out_of_range();
    test_all_requests();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
